serial_mag_cmp: RTL and testbench
=================================

SERIAL_MAG_CMP -- requirements
Module: serial_mag_cmp

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits; SHALL be >= 2.
REQ-002 Parameter EARLY_EXIT, default 0, 1 = stop scanning at first differing bit.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  request a comparison; sampled only in IDLE.
REQ-006 sgn  in  1  1 = two's-complement compare, 0 = unsigned; captured with start.
REQ-007 e  in  1  compare enable; captured with start; 0 forces a null result.
REQ-008 a  in  WIDTH  operand A; captured with start.
REQ-009 b  in  WIDTH  operand B; captured with start.
REQ-010 busy  out  1  high while a comparison is in progress (RUN state).
REQ-011 done  out  1  one-cycle pulse: result valid.
REQ-012 gt  out  1  A > B.
REQ-013 eq  out  1  A == B.
REQ-014 lt  out  1  A < B.

Function
REQ-015 FSM states SHALL be IDLE, RUN and DONE; encoding is free.
REQ-016 IDLE: start=1 SHALL capture a, b, sgn and e, set bit index to WIDTH-1, clear the decided flag and go to RUN; start=0 SHALL stay in IDLE.
REQ-017 RUN SHALL examine one bit per cycle, MSB first (index WIDTH-1 down to 0).
REQ-018 At each RUN cycle with the decided flag clear and a[i] != b[i], the block SHALL set decided and record gt = a[i] (lt = b[i]); when sgn=1 and i=WIDTH-1, the sense SHALL be inverted (gt = b[i]).
REQ-019 Once decided, later bits SHALL NOT alter the recorded relation.
REQ-020 RUN SHALL go to DONE after the index-0 cycle or, if EARLY_EXIT=1, after the cycle that sets decided.
REQ-021 DONE SHALL last exactly one cycle with done=1, then go to IDLE.
REQ-022 Latency with EARLY_EXIT=0: done SHALL be high in the cycle following edge WIDTH+1 after the edge that sampled start, regardless of data.
REQ-023 Latency with EARLY_EXIT=1 and first differing bit i: done SHALL follow edge WIDTH-i+1; equal operands take the full WIDTH+1.
REQ-024 gt/eq/lt SHALL update only on the edge entering DONE and hold until the next DONE entry; exactly one is high if captured e=1.
REQ-025 eq SHALL be 1 only if no bit differed.
REQ-026 Captured e=0: gt=eq=lt=0 at DONE; the full scan timing and the done pulse SHALL still occur.
REQ-027 start in RUN or DONE SHALL be ignored; operand changes after capture SHALL have no effect.
REQ-028 start high in the IDLE cycle immediately after DONE SHALL begin a new comparison (back-to-back allowed).
REQ-029 busy SHALL be 1 exactly in RUN; done and busy SHALL never be high together.

Reset
REQ-030 rst_n=0 SHALL immediately force IDLE, busy=0, done=0, gt=0, eq=0, lt=0 and clear captured operands and the decided flag.
REQ-031 Reset during RUN or DONE SHALL abort the comparison; no done pulse for it after release.
REQ-032 After rst_n returns high, the first start SHALL be honoured on the next rising edge.

Verification
REQ-033 WIDTH=8, EARLY_EXIT=0, sgn=0, e=1, a=8'hA5, b=8'h5A -> gt=1, eq=0, lt=0; done one cycle, 9 edges after start; busy high for 8 cycles.
REQ-034 sgn=1, a=8'h80, b=8'h01 -> lt=1; the same operands with sgn=0 -> gt=1.
REQ-035 a=b=8'h3C, e=1 -> eq=1; then a=8'h01, b=8'h00, e=0 -> gt=eq=lt=0 with the done pulse still present at 9 edges.
REQ-036 EARLY_EXIT=1, sgn=0, a=8'h80, b=8'h00 -> gt=1, done after 2 edges; a=8'h01, b=8'h00 -> done after 9 edges.
REQ-037 Start pulsed during busy with new operands -> ignored, original result reported; rst_n pulsed low mid-RUN -> all outputs 0 at once, no done, next start completes normally.

Source files
------------

// File: rtl/serial_mag_cmp.sv
// Bit-serial magnitude comparator: scans operands MSB first, one bit per cycle.
// Latency WIDTH+1 edges from start, or shorter with EARLY_EXIT; start is ignored while a compare is in flight.
module serial_mag_cmp #(
    parameter int WIDTH      = 8,
    parameter int EARLY_EXIT = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sgn,
    input  logic             e,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             gt,
    output logic             eq,
    output logic             lt
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0] IDX_MAX = IW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_sgn;
    logic             r_en;
    logic [IW-1:0]    r_idx;
    logic             r_dec;
    logic             r_gt_acc;
    logic             r_lt_acc;

    logic w_ai;
    logic w_bi;
    logic w_diff;
    logic w_inv;
    logic w_bit_gt;
    logic w_dec_n;
    logic w_gt_n;
    logic w_lt_n;
    logic w_last;

    assign w_ai     = r_a[r_idx];
    assign w_bi     = r_b[r_idx];
    assign w_diff   = w_ai ^ w_bi;
    // In two's complement the sign bit carries negative weight, so its sense flips.
    assign w_inv    = r_sgn && (r_idx == IDX_MAX);
    assign w_bit_gt = w_inv ? w_bi : w_ai;
    assign w_dec_n  = r_dec | w_diff;
    assign w_gt_n   = r_dec ? r_gt_acc : (w_diff & w_bit_gt);
    assign w_lt_n   = r_dec ? r_lt_acc : (w_diff & ~w_bit_gt);
    // A disabled compare always runs the full scan.
    assign w_last   = (r_idx == '0) ||
                      ((EARLY_EXIT != 0) && r_en && !r_dec && w_diff);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_sgn    <= 1'b0;
            r_en     <= 1'b0;
            r_idx    <= '0;
            r_dec    <= 1'b0;
            r_gt_acc <= 1'b0;
            r_lt_acc <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            gt       <= 1'b0;
            eq       <= 1'b0;
            lt       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a      <= a;
                        r_b      <= b;
                        r_sgn    <= sgn;
                        r_en     <= e;
                        r_idx    <= IDX_MAX;
                        r_dec    <= 1'b0;
                        r_gt_acc <= 1'b0;
                        r_lt_acc <= 1'b0;
                        busy     <= 1'b1;
                        r_state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_dec    <= w_dec_n;
                    r_gt_acc <= w_gt_n;
                    r_lt_acc <= w_lt_n;
                    r_idx    <= r_idx - 1'b1;
                    if (w_last) begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        gt      <= r_en & w_gt_n;
                        lt      <= r_en & w_lt_n;
                        eq      <= r_en & ~w_dec_n;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    done    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_mag_cmp.sv
// Scoreboard bench: two comparators (full scan and early exit) share stimulus;
// expected results from an arithmetic model are queued and checked when done pulses.
module tb_serial_mag_cmp;

    localparam int W = 8;

    typedef struct {
        logic gt;
        logic eq;
        logic lt;
        int   lat;
        int   scyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         sgn;
    logic         e;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   busy_v, done_v, gt_v, eq_v, lt_v;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t q0[$];
    exp_t q1[$];
    int   bcnt[2];
    logic [2:0] held[2];

    serial_mag_cmp #(.WIDTH(W), .EARLY_EXIT(0)) u_full (
        .clk(clk), .rst_n(rst_n), .start(start), .sgn(sgn), .e(e), .a(a), .b(b),
        .busy(busy_v[0]), .done(done_v[0]), .gt(gt_v[0]), .eq(eq_v[0]), .lt(lt_v[0])
    );

    serial_mag_cmp #(.WIDTH(W), .EARLY_EXIT(1)) u_early (
        .clk(clk), .rst_n(rst_n), .start(start), .sgn(sgn), .e(e), .a(a), .b(b),
        .busy(busy_v[1]), .done(done_v[1]), .gt(gt_v[1]), .eq(eq_v[1]), .lt(lt_v[1])
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic exp_t model(input logic sg, input logic en, input logic [W-1:0] aa,
                                   input logic [W-1:0] bb, input int ee, input int scyc);
        exp_t r;
        int   first;
        int   va, vb;
        first = -1;
        for (int i = W - 1; i >= 0; i--)
            if (first < 0 && aa[i] != bb[i]) first = i;
        va = sg ? int'($signed(aa)) : int'(aa);
        vb = sg ? int'($signed(bb)) : int'(bb);
        r.gt   = en && (va > vb);
        r.eq   = en && (va == vb);
        r.lt   = en && (va < vb);
        r.lat  = (ee != 0 && en && first >= 0) ? (W - first + 1) : (W + 1);
        r.scyc = scyc;
        return r;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            q0.delete();
            q1.delete();
            bcnt[0] = 0; bcnt[1] = 0;
            held[0] = 3'b000; held[1] = 3'b000;
        end else begin
            for (int k = 0; k < 2; k++) begin
                exp_t x;
                logic have;
                chk($sformatf("busy_done_excl%0d", k), int'(busy_v[k] & done_v[k]), 0);
                if (busy_v[k]) bcnt[k]++;
                if (done_v[k]) begin
                    have = (k == 0) ? (q0.size() > 0) : (q1.size() > 0);
                    if (!have) begin
                        chk($sformatf("spurious_done%0d", k), 1, 0);
                    end else begin
                        x = (k == 0) ? q0.pop_front() : q1.pop_front();
                        chk($sformatf("latency%0d", k), cyc - x.scyc, x.lat);
                        chk($sformatf("busy_cycles%0d", k), bcnt[k], x.lat - 1);
                        chk($sformatf("gt_eq_lt%0d", k), int'({gt_v[k], eq_v[k], lt_v[k]}),
                            int'({x.gt, x.eq, x.lt}));
                    end
                    held[k] = {gt_v[k], eq_v[k], lt_v[k]};
                    bcnt[k] = 0;
                end else begin
                    chk($sformatf("result_hold%0d", k), int'({gt_v[k], eq_v[k], lt_v[k]}),
                        int'(held[k]));
                end
            end
        end
    end

    task automatic issue(input logic sg, input logic en, input logic [W-1:0] aa,
                         input logic [W-1:0] bb);
        a = aa; b = bb; sgn = sg; e = en; start = 1'b1;
        q0.push_back(model(sg, en, aa, bb, 0, cyc));
        q1.push_back(model(sg, en, aa, bb, 1, cyc));
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); sgn = 1'($urandom); e = 1'($urandom);
    endtask

    // Called at a negedge; returns at the negedge of the first IDLE cycle of the full-scan DUT.
    task automatic run(input logic sg, input logic en, input logic [W-1:0] aa,
                       input logic [W-1:0] bb, input logic upset);
        int t;
        issue(sg, en, aa, bb);
        if (upset) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            a = W'($urandom); b = W'($urandom);
        end
        t = 0;
        #1;
        while ((q0.size() != 0 || q1.size() != 0) && t < 4 * W) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (q0.size() != 0 || q1.size() != 0) begin
            chk("done_timeout", q0.size() + q1.size(), 0);
            q0.delete();
            q1.delete();
        end
        @(negedge clk);
    endtask

    logic [7:0] dir_a [9] = '{8'hA5, 8'h80, 8'h80, 8'h3C, 8'h01, 8'h80, 8'h01, 8'h7F, 8'hFF};
    logic [7:0] dir_b [9] = '{8'h5A, 8'h01, 8'h01, 8'h3C, 8'h00, 8'h00, 8'h00, 8'h80, 8'hFE};
    logic       dir_s [9] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic       dir_e [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

    initial begin
        rst_n = 1'b0; start = 1'b0; sgn = 1'b0; e = 1'b0; a = '0; b = '0;
        #1;
        for (int k = 0; k < 2; k++)
            chk($sformatf("reset_outputs%0d", k),
                int'({busy_v[k], done_v[k], gt_v[k], eq_v[k], lt_v[k]}), 0);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 9; i++)
            run(dir_s[i], dir_e[i], dir_a[i], dir_b[i], 1'b0);

        // Start pulsed while busy with different operands must be ignored.
        run(1'b0, 1'b1, 8'h10, 8'h20, 1'b1);

        // Reset in the middle of a scan aborts it immediately.
        issue(1'b0, 1'b1, 8'h0F, 8'h0E);
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++)
            chk($sformatf("midrun_reset%0d", k),
                int'({busy_v[k], done_v[k], gt_v[k], eq_v[k], lt_v[k]}), 0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (2 * W) @(negedge clk);
        run(1'b1, 1'b1, 8'hF0, 8'h0F, 1'b0);

        for (int i = 0; i < 40; i++)
            run(1'($urandom), ($urandom_range(0, 7) != 0), W'($urandom), W'($urandom),
                ($urandom_range(0, 3) == 0));
        // Equal operands with random signedness exercise the eq path.
        for (int i = 0; i < 4; i++) begin
            logic [W-1:0] v;
            v = W'($urandom);
            run(1'($urandom), 1'b1, v, v, 1'b0);
        end

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
